ifetch_bridge: RTL and testbench

IFETCH_BRIDGE -- requirements
Module: ifetch_bridge

---
 rtl/ifetch_bridge_if.sv | 40 ++++
 rtl/ifetch_bridge.sv | 113 +++++++++++
 tb/tb_ifetch_bridge.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_bridge_if.sv
// ifetch_bridge_if: bundles the core-side fetch handshake and the memory
// read channels of the instruction fetch bridge.
//   slave  : bridge view (drives fetch_ready, inst_*, mem_ar*, mem_rready)
//   master : environment view (core plus memory)
interface ifetch_bridge_if #(
  parameter int DATA_LEN = 32
);
  // core side
  logic                fetch_req;
  logic [DATA_LEN-1:0] fetch_pc;
  logic                fetch_ready;
  logic                inst_valid;
  logic [DATA_LEN-1:0] inst_out;
  logic [DATA_LEN-1:0] inst_pc;
  logic                fetch_err;
  logic                inst_ack;
  logic                flush;
  // memory side
  logic                mem_arvalid;
  logic [DATA_LEN-1:0] mem_araddr;
  logic                mem_arready;
  logic                mem_rvalid;
  logic [DATA_LEN-1:0] mem_rdata;
  logic [1:0]          mem_rresp;
  logic                mem_rready;

  modport slave (
    input  fetch_req, fetch_pc, inst_ack, flush,
    input  mem_arready, mem_rvalid, mem_rdata, mem_rresp,
    output fetch_ready, inst_valid, inst_out, inst_pc, fetch_err,
    output mem_arvalid, mem_araddr, mem_rready
  );

  modport master (
    output fetch_req, fetch_pc, inst_ack, flush,
    output mem_arready, mem_rvalid, mem_rdata, mem_rresp,
    input  fetch_ready, inst_valid, inst_out, inst_pc, fetch_err,
    input  mem_arvalid, mem_araddr, mem_rready
  );
endinterface

// File: rtl/ifetch_bridge.sv
// ifetch_bridge: single-outstanding instruction fetch bridge between a core
// fetch port and a memory read address/data channel pair.
// Optional feature: define IFETCH_ALIGN_CHECK_EN to reject fetch addresses
// with fetch_pc[1:0] != 0 locally (error returned, no memory access).
// Every bus-facing output is a flop, so no memory input reaches a core
// output combinationally.
module ifetch_bridge #(
  parameter int DATA_LEN = 32
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  ifetch_bridge_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR    = 3'd1,
    WAIT    = 3'd2,
    HOLD    = 3'd3,
    DISCARD = 3'd4
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   flush_pending;
  logic   misaligned;
  logic   accept;

`ifdef IFETCH_ALIGN_CHECK_EN
  assign misaligned = |bus.fetch_pc[1:0];
`else
  assign misaligned = 1'b0;
`endif

  // a request is taken only in IDLE and never alongside a flush
  assign accept = (state == IDLE) && bus.fetch_req && !bus.flush;

  // next-state selection; flush always wins over normal progress
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = misaligned ? HOLD : ADDR;
        end
      end
      ADDR: begin
        // the address is never withdrawn; a flush only redirects the response
        if (bus.mem_arready) begin
          state_nxt = (bus.flush || flush_pending) ? DISCARD : WAIT;
        end
      end
      WAIT: begin
        if (bus.mem_rvalid) begin
          state_nxt = bus.flush ? IDLE : HOLD;
        end else if (bus.flush) begin
          state_nxt = DISCARD;
        end
      end
      DISCARD: begin
        if (bus.mem_rvalid) begin
          state_nxt = IDLE;
        end
      end
      HOLD: begin
        if (bus.flush || bus.inst_ack) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // state, registered handshake flags and held fetch data
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state           <= IDLE;
      flush_pending   <= 1'b0;
      bus.fetch_ready <= 1'b1;
      bus.inst_valid  <= 1'b0;
      bus.mem_arvalid <= 1'b0;
      bus.mem_rready  <= 1'b0;
      bus.fetch_err   <= 1'b0;
      bus.inst_out    <= '0;
      bus.inst_pc     <= '0;
      bus.mem_araddr  <= '0;
    end else begin
      state           <= state_nxt;
      bus.fetch_ready <= (state_nxt == IDLE);
      bus.inst_valid  <= (state_nxt == HOLD);
      bus.mem_arvalid <= (state_nxt == ADDR);
      bus.mem_rready  <= (state_nxt == WAIT) || (state_nxt == DISCARD);
      // remembers a flush seen while the address is still waiting for arready
      flush_pending   <= (state_nxt == ADDR) &&
                         (flush_pending || ((state == ADDR) && bus.flush));
      if (accept) begin
        if (misaligned) begin
          bus.inst_out  <= '0;
          bus.inst_pc   <= bus.fetch_pc;
          bus.fetch_err <= 1'b1;
        end else begin
          bus.mem_araddr <= bus.fetch_pc;
        end
      end
      if ((state == WAIT) && bus.mem_rvalid && !bus.flush) begin
        bus.inst_out  <= bus.mem_rdata;
        bus.inst_pc   <= bus.mem_araddr;
        bus.fetch_err <= |bus.mem_rresp;
      end
    end
  end

endmodule

// File: tb/tb_ifetch_bridge.sv
// tb_ifetch_bridge: directed bench for ifetch_bridge. A table of complete
// fetches (address/response wait states, response codes) is replayed in a
// loop, followed by hand-written flush, ack, misalignment and reset cases.
module tb_ifetch_bridge;

  logic sys_clk;
  logic sys_rst_n;
  int   n_run;
  int   n_fail;
  int   ar_hs;

  ifetch_bridge_if #(.DATA_LEN(32)) bus ();

  ifetch_bridge #(.DATA_LEN(32)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // count address handshakes seen on the bus
  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) ar_hs <= 0;
    else if (bus.mem_arvalid && bus.mem_arready) ar_hs <= ar_hs + 1;
  end

  typedef struct {
    logic [31:0] pc;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    int          ar_wait;
    int          r_wait;
    logic        exp_err;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // one complete fetch with the given wait states, ending back in IDLE
  task automatic run_fetch(input vec_t v, input int idx);
    string t;
    int    hs0;
    t   = $sformatf("v%0d", idx);
    hs0 = ar_hs;
    chk({t, ".ready0"}, {31'd0, bus.fetch_ready}, 32'd1);
    bus.fetch_req = 1'b1;
    bus.fetch_pc  = v.pc;
    tick();
    bus.fetch_req = 1'b0;
    for (int i = 0; i < v.ar_wait; i++) begin
      chk({t, ".arvalid_bp"}, {31'd0, bus.mem_arvalid}, 32'd1);
      chk({t, ".araddr_bp"}, bus.mem_araddr, v.pc);
      tick();
    end
    chk({t, ".arvalid"}, {31'd0, bus.mem_arvalid}, 32'd1);
    chk({t, ".araddr"}, bus.mem_araddr, v.pc);
    chk({t, ".valid_early"}, {31'd0, bus.inst_valid}, 32'd0);
    bus.mem_arready = 1'b1;
    tick();
    bus.mem_arready = 1'b0;
    chk({t, ".arvalid_off"}, {31'd0, bus.mem_arvalid}, 32'd0);
    for (int i = 0; i < v.r_wait; i++) begin
      chk({t, ".rready_wait"}, {31'd0, bus.mem_rready}, 32'd1);
      chk({t, ".valid_wait"}, {31'd0, bus.inst_valid}, 32'd0);
      tick();
    end
    chk({t, ".rready"}, {31'd0, bus.mem_rready}, 32'd1);
    chk({t, ".valid_pre"}, {31'd0, bus.inst_valid}, 32'd0);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = v.rdata;
    bus.mem_rresp  = v.rresp;
    tick();
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'h0;
    bus.mem_rresp  = 2'b00;
    chk({t, ".handshakes"}, ar_hs - hs0, 32'd1);
    for (int h = 0; h < 2; h++) begin
      chk({t, ".inst_valid"}, {31'd0, bus.inst_valid}, 32'd1);
      chk({t, ".inst_out"}, bus.inst_out, v.rdata);
      chk({t, ".inst_pc"}, bus.inst_pc, v.pc);
      chk({t, ".fetch_err"}, {31'd0, bus.fetch_err}, {31'd0, v.exp_err});
      chk({t, ".ready_hold"}, {31'd0, bus.fetch_ready}, 32'd0);
      chk({t, ".rready_hold"}, {31'd0, bus.mem_rready}, 32'd0);
      if (h == 0) tick();
    end
    bus.inst_ack = 1'b1;
    tick();
    bus.inst_ack = 1'b0;
    chk({t, ".valid_ack"}, {31'd0, bus.inst_valid}, 32'd0);
    chk({t, ".ready_ack"}, {31'd0, bus.fetch_ready}, 32'd1);
  endtask

  // zero-wait fetch that stops with the instruction held
  task automatic to_hold(input logic [31:0] pc, input logic [31:0] rdata);
    bus.fetch_req = 1'b1;
    bus.fetch_pc  = pc;
    tick();
    bus.fetch_req   = 1'b0;
    bus.mem_arready = 1'b1;
    tick();
    bus.mem_arready = 1'b0;
    bus.mem_rvalid  = 1'b1;
    bus.mem_rdata   = rdata;
    tick();
    bus.mem_rvalid = 1'b0;
    chk("to_hold.valid", {31'd0, bus.inst_valid}, 32'd1);
    chk("to_hold.inst_out", bus.inst_out, rdata);
  endtask

  // stop a hung run with a failure line
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_run = 0;
    n_fail = 0;
    vecs[0] = '{32'h8000_0000, 32'h0010_0073, 2'b00, 0, 0, 1'b0};
    vecs[1] = '{32'h8000_0004, 32'h0000_0013, 2'b00, 4, 0, 1'b0};
    vecs[2] = '{32'h8000_0008, 32'h1234_5678, 2'b10, 0, 2, 1'b1};
    vecs[3] = '{32'h8000_000C, 32'hCAFE_F00D, 2'b01, 1, 1, 1'b1};
    vecs[4] = '{32'h0000_0010, 32'hFFFF_FFFF, 2'b11, 2, 0, 1'b1};
    vecs[5] = '{32'h7FFF_FFFC, 32'h0000_A001, 2'b00, 0, 3, 1'b0};

    sys_rst_n       = 1'b0;
    bus.fetch_req   = 1'b0;
    bus.fetch_pc    = 32'h0;
    bus.inst_ack    = 1'b0;
    bus.flush       = 1'b0;
    bus.mem_arready = 1'b0;
    bus.mem_rvalid  = 1'b0;
    bus.mem_rdata   = 32'h0;
    bus.mem_rresp   = 2'b00;
    repeat (2) @(posedge sys_clk);
    #1;
    chk("rst.fetch_ready", {31'd0, bus.fetch_ready}, 32'd1);
    chk("rst.inst_valid", {31'd0, bus.inst_valid}, 32'd0);
    chk("rst.arvalid", {31'd0, bus.mem_arvalid}, 32'd0);
    chk("rst.rready", {31'd0, bus.mem_rready}, 32'd0);
    chk("rst.fetch_err", {31'd0, bus.fetch_err}, 32'd0);
    chk("rst.inst_out", bus.inst_out, 32'h0);
    chk("rst.inst_pc", bus.inst_pc, 32'h0);
    chk("rst.araddr", bus.mem_araddr, 32'h0);
    sys_rst_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) run_fetch(vecs[i], i);

    // flush while the address waits; arready arrives two cycles later
    bus.fetch_req = 1'b1;
    bus.fetch_pc  = 32'h8000_0020;
    tick();
    bus.fetch_req = 1'b0;
    bus.flush     = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("fa.arvalid1", {31'd0, bus.mem_arvalid}, 32'd1);
    chk("fa.araddr1", bus.mem_araddr, 32'h8000_0020);
    tick();
    chk("fa.arvalid2", {31'd0, bus.mem_arvalid}, 32'd1);
    bus.mem_arready = 1'b1;
    tick();
    bus.mem_arready = 1'b0;
    chk("fa.arvalid_off", {31'd0, bus.mem_arvalid}, 32'd0);
    chk("fa.rready", {31'd0, bus.mem_rready}, 32'd1);
    chk("fa.valid_drain", {31'd0, bus.inst_valid}, 32'd0);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hDEAD_BEEF;
    tick();
    bus.mem_rvalid = 1'b0;
    chk("fa.valid_after", {31'd0, bus.inst_valid}, 32'd0);
    chk("fa.ready", {31'd0, bus.fetch_ready}, 32'd1);
    chk("fa.rready_off", {31'd0, bus.mem_rready}, 32'd0);
    chk("fa.inst_out_kept", bus.inst_out, 32'h0000_A001);

    // flush coincident with the response in WAIT drops the data
    bus.fetch_req = 1'b1;
    bus.fetch_pc  = 32'h8000_0030;
    tick();
    bus.fetch_req   = 1'b0;
    bus.mem_arready = 1'b1;
    tick();
    bus.mem_arready = 1'b0;
    bus.flush       = 1'b1;
    bus.mem_rvalid  = 1'b1;
    bus.mem_rdata   = 32'h1111_1111;
    tick();
    bus.flush      = 1'b0;
    bus.mem_rvalid = 1'b0;
    chk("fwr.valid", {31'd0, bus.inst_valid}, 32'd0);
    chk("fwr.ready", {31'd0, bus.fetch_ready}, 32'd1);
    chk("fwr.inst_out_kept", bus.inst_out, 32'h0000_A001);

    // flush in WAIT before the response: response still drained
    bus.fetch_req = 1'b1;
    bus.fetch_pc  = 32'h8000_0034;
    tick();
    bus.fetch_req   = 1'b0;
    bus.mem_arready = 1'b1;
    tick();
    bus.mem_arready = 1'b0;
    bus.flush       = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("fw.rready_discard", {31'd0, bus.mem_rready}, 32'd1);
    chk("fw.ready_discard", {31'd0, bus.fetch_ready}, 32'd0);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h2222_2222;
    tick();
    bus.mem_rvalid = 1'b0;
    chk("fw.valid", {31'd0, bus.inst_valid}, 32'd0);
    chk("fw.ready", {31'd0, bus.fetch_ready}, 32'd1);
    chk("fw.inst_out_kept", bus.inst_out, 32'h0000_A001);

    // request with flush in IDLE is ignored
    bus.fetch_req = 1'b1;
    bus.flush     = 1'b1;
    bus.fetch_pc  = 32'h8000_0040;
    tick();
    bus.fetch_req = 1'b0;
    bus.flush     = 1'b0;
    chk("fi.arvalid", {31'd0, bus.mem_arvalid}, 32'd0);
    chk("fi.ready", {31'd0, bus.fetch_ready}, 32'd1);

    // flush in HOLD releases the instruction
    to_hold(32'h8000_0060, 32'hABCD_0001);
    bus.flush    = 1'b1;
    bus.inst_ack = 1'b1;
    tick();
    bus.flush    = 1'b0;
    bus.inst_ack = 1'b0;
    chk("fh.valid", {31'd0, bus.inst_valid}, 32'd0);
    chk("fh.ready", {31'd0, bus.fetch_ready}, 32'd1);

    // request alongside inst_ack is not taken; it is taken one cycle later
    to_hold(32'h8000_0064, 32'hABCD_0002);
    bus.inst_ack  = 1'b1;
    bus.fetch_req = 1'b1;
    bus.fetch_pc  = 32'h8000_0070;
    tick();
    bus.inst_ack = 1'b0;
    chk("ar.arvalid_ack", {31'd0, bus.mem_arvalid}, 32'd0);
    chk("ar.ready_ack", {31'd0, bus.fetch_ready}, 32'd1);
    tick();
    bus.fetch_req = 1'b0;
    chk("ar.arvalid_next", {31'd0, bus.mem_arvalid}, 32'd1);
    chk("ar.araddr_next", bus.mem_araddr, 32'h8000_0070);
    bus.mem_arready = 1'b1;
    tick();
    bus.mem_arready = 1'b0;
    bus.mem_rvalid  = 1'b1;
    bus.mem_rdata   = 32'h3333_3333;
    tick();
    bus.mem_rvalid = 1'b0;
    chk("ar.inst_pc", bus.inst_pc, 32'h8000_0070);
    bus.inst_ack = 1'b1;
    tick();
    bus.inst_ack = 1'b0;

    // misaligned fetch address
`ifdef IFETCH_ALIGN_CHECK_EN
    begin
      int hs0;
      hs0 = ar_hs;
      bus.fetch_req = 1'b1;
      bus.fetch_pc  = 32'h8000_0002;
      tick();
      bus.fetch_req = 1'b0;
      chk("mis.valid", {31'd0, bus.inst_valid}, 32'd1);
      chk("mis.err", {31'd0, bus.fetch_err}, 32'd1);
      chk("mis.inst_pc", bus.inst_pc, 32'h8000_0002);
      chk("mis.inst_out", bus.inst_out, 32'h0);
      chk("mis.arvalid", {31'd0, bus.mem_arvalid}, 32'd0);
      bus.inst_ack = 1'b1;
      tick();
      bus.inst_ack = 1'b0;
      chk("mis.ready", {31'd0, bus.fetch_ready}, 32'd1);
      chk("mis.no_hs", ar_hs - hs0, 32'd0);
    end
`else
    bus.fetch_req = 1'b1;
    bus.fetch_pc  = 32'h8000_0002;
    tick();
    bus.fetch_req = 1'b0;
    chk("mis.arvalid", {31'd0, bus.mem_arvalid}, 32'd1);
    chk("mis.araddr", bus.mem_araddr, 32'h8000_0002);
    bus.mem_arready = 1'b1;
    tick();
    bus.mem_arready = 1'b0;
    bus.mem_rvalid  = 1'b1;
    bus.mem_rdata   = 32'h0000_0013;
    tick();
    bus.mem_rvalid = 1'b0;
    chk("mis.inst_pc", bus.inst_pc, 32'h8000_0002);
    chk("mis.err", {31'd0, bus.fetch_err}, 32'd0);
    bus.inst_ack = 1'b1;
    tick();
    bus.inst_ack = 1'b0;
`endif

    // asynchronous reset in the middle of a WAIT cycle
    bus.fetch_req = 1'b1;
    bus.fetch_pc  = 32'h8000_0080;
    tick();
    bus.fetch_req   = 1'b0;
    bus.mem_arready = 1'b1;
    tick();
    bus.mem_arready = 1'b0;
    chk("rw.rready_pre", {31'd0, bus.mem_rready}, 32'd1);
    #3;
    sys_rst_n = 1'b0;
    #1;
    chk("rw.rready", {31'd0, bus.mem_rready}, 32'd0);
    chk("rw.valid", {31'd0, bus.inst_valid}, 32'd0);
    chk("rw.arvalid", {31'd0, bus.mem_arvalid}, 32'd0);
    chk("rw.ready", {31'd0, bus.fetch_ready}, 32'd1);
    chk("rw.araddr", bus.mem_araddr, 32'h0);
    chk("rw.inst_out", bus.inst_out, 32'h0);
    #2;
    sys_rst_n      = 1'b1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h4444_4444;
    tick();
    bus.mem_rvalid = 1'b0;
    chk("rw.post_valid", {31'd0, bus.inst_valid}, 32'd0);
    chk("rw.post_ready", {31'd0, bus.fetch_ready}, 32'd1);
    chk("rw.post_rready", {31'd0, bus.mem_rready}, 32'd0);
    chk("rw.post_inst_out", bus.inst_out, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
